lzc_iter: RTL and testbench

Parametrised, iterative leading-digit counter for the FMA normalisation path. It scans a WIDTH-bit sum CHUNK bits per cycle, MSB first, and returns the normalisation shift count and an all-zero flag. Mode selects leading-one search (count leading zeros) or leading-zero search (count leading ones). A start/ready/done handshake lets the FMA control sequencer trade latency for area against the single-cycle combinational counter.

---
 rtl/lzc_iter.sv | 101 ++++++++++
 tb/tb_lzc_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lzc_iter.sv
// Iterative leading-digit counter: scans a WIDTH-bit operand CHUNK bits per
// cycle, MSB first, returning the normalisation shift count and a no-match flag.
module lzc_iter #(
   parameter int WIDTH = 158,
   parameter int CHUNK = 32,
   localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] sum,
   input  logic             flush,
   output logic             ready,
   output logic             done,
   output logic [CW-1:0]    normcnt,
   output logic             sumzero
);
   localparam int TW = NCH * CHUNK;
   localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [TW-1:0]   vreg;
   logic [TW-1:0]   vin;
   logic [CHUNK-1:0] cur;
   logic [CW-1:0]   p;
   logic [CW-1:0]   base;
   logic            hit;
   logic            last;

   assign ready = (state == IDLE);

   // Operand is left-aligned so the last chunk carries zero padding at the LSB end.
   always_comb begin
      vin = '0;
      vin[TW-1 -: WIDTH] = mode ? ~sum : sum;
   end

   // The chunk under test is always the top of vreg; vreg shifts up each step.
   assign cur = vreg[TW-1 -: CHUNK];

   always_comb begin
      hit = 1'b0;
      p   = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (!hit && cur[CHUNK-1-i]) begin
            hit = 1'b1;
            p   = CW'(i);
         end
      end
   end

   assign base = CW'(int'(k) * CHUNK);
   assign last = (k == KW'(NCH - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         k       <= '0;
         vreg    <= '0;
         done    <= 1'b0;
         normcnt <= '0;
         sumzero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vreg  <= vin;
                  k     <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (flush) begin
                  state <= IDLE;
               end else if (hit) begin
                  normcnt <= base + p;
                  sumzero <= 1'b0;
                  done    <= 1'b1;
                  state   <= IDLE;
               end else if (last) begin
                  // Saturated count; sumzero tells it apart from a bit-0 match.
                  normcnt <= CW'(WIDTH - 1);
                  sumzero <= 1'b1;
                  done    <= 1'b1;
                  state   <= IDLE;
               end else begin
                  k    <= k + KW'(1);
                  vreg <= vreg << CHUNK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lzc_iter.sv
// Scoreboarded directed bench for lzc_iter plus a parameter sweep (CHUNK 1/7/158, WIDTH 8).
module tb_lzc_iter;
   typedef struct {int cnt; int z; int lat; int acc;} exp_t;

   logic clk = 1'b0;
   logic reset_n, start_m, start_s, mode, flush;
   logic [157:0] sum;
   logic ready_m, done_m, zero_m;
   logic [7:0] cnt_m;
   logic ready1, done1, zero1, ready7, done7, zero7, readyw, donew, zerow, ready8, done8, zero8;
   logic [7:0] cnt1, cnt7, cntw;
   logic [2:0] cnt8;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t q0[$], q1[$], q7[$], qw[$], q8[$];
   exp_t pe;
   logic [157:0] pat[5];
   bit pm[5];

   lzc_iter dut (.clk(clk), .reset_n(reset_n), .start(start_m), .mode(mode), .sum(sum),
      .flush(flush), .ready(ready_m), .done(done_m), .normcnt(cnt_m), .sumzero(zero_m));
   lzc_iter #(.WIDTH(158), .CHUNK(1)) s1 (.clk(clk), .reset_n(reset_n), .start(start_s),
      .mode(mode), .sum(sum), .flush(1'b0), .ready(ready1), .done(done1), .normcnt(cnt1), .sumzero(zero1));
   lzc_iter #(.WIDTH(158), .CHUNK(7)) s7 (.clk(clk), .reset_n(reset_n), .start(start_s),
      .mode(mode), .sum(sum), .flush(1'b0), .ready(ready7), .done(done7), .normcnt(cnt7), .sumzero(zero7));
   lzc_iter #(.WIDTH(158), .CHUNK(158)) sw (.clk(clk), .reset_n(reset_n), .start(start_s),
      .mode(mode), .sum(sum), .flush(1'b0), .ready(readyw), .done(donew), .normcnt(cntw), .sumzero(zerow));
   lzc_iter #(.WIDTH(8), .CHUNK(3)) s8 (.clk(clk), .reset_n(reset_n), .start(start_s),
      .mode(mode), .sum(sum[7:0]), .flush(1'b0), .ready(ready8), .done(done8), .normcnt(cnt8), .sumzero(zero8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [157:0] s, input bit md, input int w, input int c, input int acc);
      exp_t e;
      bit found = 0;
      e.cnt = w - 1; e.z = 1; e.acc = acc;
      for (int i = w - 1; i >= 0; i--)
         if (!found && ((s[i] ^ md) === 1'b1)) begin
            found = 1; e.cnt = w - 1 - i; e.z = 0;
         end
      e.lat = e.z ? (w + c - 1) / c : e.cnt / c + 1;
      return e;
   endfunction

   task automatic score(input string tag, input exp_t e, input logic [31:0] cnt, input logic [31:0] z);
      chk({tag, "_cnt"}, cnt, e.cnt);
      chk({tag, "_zero"}, z, e.z);
      chk({tag, "_lat"}, cyc - e.acc, e.lat);
   endtask

   always @(negedge clk) if (done_m) begin
      if (q0.size() == 0) chk("main_extra_done", 32'(done_m), 0);
      else begin
         score("main", q0.pop_front(), 32'(cnt_m), 32'(zero_m));
         chk("main_ready_in_done", 32'(ready_m), 1);
      end
   end
   always @(negedge clk) if (done1) begin
      if (q1.size() == 0) chk("c1_extra_done", 32'(done1), 0);
      else score("c1", q1.pop_front(), 32'(cnt1), 32'(zero1));
   end
   always @(negedge clk) if (done7) begin
      if (q7.size() == 0) chk("c7_extra_done", 32'(done7), 0);
      else score("c7", q7.pop_front(), 32'(cnt7), 32'(zero7));
   end
   always @(negedge clk) if (donew) begin
      if (qw.size() == 0) chk("c158_extra_done", 32'(donew), 0);
      else score("c158", qw.pop_front(), 32'(cntw), 32'(zerow));
   end
   always @(negedge clk) if (done8) begin
      if (q8.size() == 0) chk("w8_extra_done", 32'(done8), 0);
      else score("w8", q8.pop_front(), 32'(cnt8), 32'(zero8));
   end

   task automatic wait_main_idle();
      int n = 0;
      while ((q0.size() != 0 || ready_m !== 1'b1) && n < 400) begin @(negedge clk); n++; end
      chk("main_idle_wait", 32'(q0.size()), 0);
   endtask

   task automatic go(input bit md, input logic [157:0] s);
      wait_main_idle();
      mode = md; sum = s; start_m = 1'b1;
      q0.push_back(model(s, md, 158, 32, cyc + 1));
      @(negedge clk);
      start_m = 1'b0;
      wait_main_idle();
   endtask

   task automatic sweep(input bit md, input logic [157:0] s);
      int n = 0;
      mode = md; sum = s; start_s = 1'b1;
      q1.push_back(model(s, md, 158, 1, cyc + 1));
      q7.push_back(model(s, md, 158, 7, cyc + 1));
      qw.push_back(model(s, md, 158, 158, cyc + 1));
      q8.push_back(model(s, md, 8, 3, cyc + 1));
      @(negedge clk);
      start_s = 1'b0;
      while ((q1.size() + q7.size() + qw.size() + q8.size()) != 0 && n < 400) begin @(negedge clk); n++; end
      chk("sweep_wait", 32'(q1.size() + q7.size() + qw.size() + q8.size()), 0);
      @(negedge clk);
   endtask

   // Accepts with flush at the following edge: no done, outputs keep pe.
   task automatic flush_after(input logic [157:0] s);
      wait_main_idle();
      mode = 1'b0; sum = s; start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", 32'(ready_m), 1);
      chk("flush_done", 32'(done_m), 0);
      chk("flush_cnt_hold", 32'(cnt_m), pe.cnt);
      chk("flush_zero_hold", 32'(zero_m), pe.z);
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start_m = 1'b0; start_s = 1'b0; mode = 1'b0; flush = 1'b0; sum = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready_m), 1);
      chk("rst_done", 32'(done_m), 0);
      chk("rst_cnt", 32'(cnt_m), 0);
      chk("rst_zero", 32'(zero_m), 0);
      reset_n = 1'b1;
      @(negedge clk);

      go(1'b0, 158'd1 << 157);
      go(1'b0, 158'd1);
      go(1'b0, '0);
      go(1'b0, 158'd1 << 126);
      go(1'b0, 158'd1 << 125);
      go(1'b1, ~(158'd1 << 100));
      go(1'b1, '1);

      // start held high; inputs scrambled while scanning
      pat[0] = 158'd1 << 157; pm[0] = 1'b0;
      pat[1] = ~(158'd1 << 100); pm[1] = 1'b1;
      pat[2] = 158'd1 << 125; pm[2] = 1'b0;
      pat[3] = '0; pm[3] = 1'b0;
      pat[4] = '1; pm[4] = 1'b1;
      wait_main_idle();
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         mode = pm[i]; sum = pat[i]; start_m = 1'b1;
         e = model(pat[i], pm[i], 158, 32, cyc + 1);
         q0.push_back(e);
         @(negedge clk);
         for (int j = 0; j < e.lat; j++) begin
            mode = 1'($urandom);
            sum = 158'({$urandom, $urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
         end
      end
      start_m = 1'b0;
      wait_main_idle();

      pe = model(158'd1 << 140, 1'b0, 158, 32, 0);
      go(1'b0, 158'd1 << 140);
      flush_after('0);
      flush_after(158'd1 << 157);

      go(1'b1, ~(158'd1 << 100));
      chk("pre_reset_cnt", 32'(cnt_m), 57);
      mode = 1'b0; sum = '0; start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midreset_ready", 32'(ready_m), 1);
      chk("midreset_done", 32'(done_m), 0);
      chk("midreset_cnt", 32'(cnt_m), 0);
      chk("midreset_zero", 32'(zero_m), 0);
      repeat (8) @(negedge clk);

      foreach (pat[i]) sweep(pm[i], pat[i]);
      for (int b = 0; b < 158; b += 13) begin
         sweep(1'b0, 158'd1 << b);
         sweep(1'b1, ~(158'd1 << b));
      end
      for (int r = 0; r < 8; r++)
         sweep(1'(r), 158'({$urandom, $urandom, $urandom, $urandom, $urandom}) >> $urandom_range(0, 157));

      chk("queues_drained", 32'(q0.size() + q1.size() + q7.size() + qw.size() + q8.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
